// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared stall bus layout, stall codes and sequencer states
// Purpose: one place for the stall vector width, per-stage bit positions,
//          the priority stall codes and the sequencer state encoding.
// Ports:   none (package).
package pipeline_stall_ctrl_pkg;

   localparam int STALL_BUS = 6;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   typedef logic [STALL_BUS-1:0] stall_t;

   // Each code holds the requesting stage and everything upstream of it.
   localparam stall_t STALL_NONE = 6'b000000;
   localparam stall_t STALL_LOAD = 6'b000111;
   localparam stall_t STALL_EXB  = 6'b001111;
   localparam stall_t STALL_MEMB = 6'b011111;
   localparam stall_t STALL_ALL  = 6'b111111;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      EXC_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_stall_encoder.sv
// rtl/pipeline_stall_ctrl_stall_encoder.sv - priority encoder from state and requests to stall vector
// Purpose: purely combinational; maps sequencer state plus the live hazard
//          requests onto the 6-bit per-stage hold vector.
// Ports:   i_state          current sequencer state
//          i_exc_req        exception/eret from MEM
//          i_stall_req_mem  MEM bus wait
//          i_stall_req_ex   EX multi-cycle busy
//          i_load_hazard    either ID operand waits on a load
//          o_stall          per-stage hold vector (bit0 PC .. bit5 WB)
module pipeline_stall_ctrl_stall_encoder
   import pipeline_stall_ctrl_pkg::*;
(
   input  state_t i_state,
   input  logic   i_exc_req,
   input  logic   i_stall_req_mem,
   input  logic   i_stall_req_ex,
   input  logic   i_load_hazard,
   output stall_t o_stall
);

   always_comb begin
      o_stall = STALL_NONE;
      case (i_state)
         RUN: begin
            // Exception freezes WB too so the faulting instruction never commits.
            if (i_exc_req)            o_stall = STALL_ALL;
            else if (i_stall_req_mem) o_stall = STALL_MEMB;
            else if (i_stall_req_ex)  o_stall = STALL_EXB;
            else if (i_load_hazard)   o_stall = STALL_LOAD;
            else                      o_stall = STALL_NONE;
         end
         EXC_WAIT: o_stall = STALL_ALL;
         FLUSH:    o_stall = STALL_NONE;
         default:  o_stall = STALL_NONE;
      endcase
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - central stall/flush sequencer for the 5-stage core
// Purpose: combines hazard requests into a per-stage stall vector, sequences
//          exception flushes (deferring them behind a MEM bus wait), and keeps
//          stall performance / EX timeout status.
// Ports:   clk, rst (async, active-low)
//          load_related_1/2  ID load-use hazards
//          stall_req_ex      EX busy
//          stall_req_mem     MEM bus wait
//          exc_req, exc_pc   exception/eret request and redirect target
//          stall             per-stage hold vector (combinational)
//          flush, flush_pc   registered flush pulse and redirect PC
//          stall_cycles      wrapping count of cycles with any stall
//          stall_timeout     sticky EX-stall timeout flag
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES  = 1,
   parameter int STALL_TIMEOUT = 1024,
   parameter int CNT_WIDTH     = 32
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_related_1,
   input  logic                 load_related_2,
   input  logic                 stall_req_ex,
   input  logic                 stall_req_mem,
   input  logic                 exc_req,
   input  logic [31:0]          exc_pc,
   output logic [STALL_BUS-1:0] stall,
   output logic                 flush,
   output logic [31:0]          flush_pc,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic                 stall_timeout
);

   localparam int               EX_CW      = $clog2(STALL_TIMEOUT + 1);
   localparam logic [EX_CW-1:0] EX_LIMIT   = EX_CW'(STALL_TIMEOUT);
   localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_flush_cnt;
   logic [EX_CW-1:0] r_ex_cnt;
   logic [EX_CW-1:0] w_ex_cnt_nxt;
   logic             w_start_flush;
   logic             w_latch_pc;
   stall_t           w_enc_stall;

   pipeline_stall_ctrl_stall_encoder u_enc (
      .i_state         (r_state),
      .i_exc_req       (exc_req),
      .i_stall_req_mem (stall_req_mem),
      .i_stall_req_ex  (stall_req_ex),
      .i_load_hazard   (load_related_1 | load_related_2),
      .o_stall         (w_enc_stall)
   );

   // Reset forces the hold vector low even while requests are still asserted.
   assign stall = rst ? w_enc_stall : STALL_NONE;

   always_comb begin
      w_state_nxt   = r_state;
      w_start_flush = 1'b0;
      w_latch_pc    = 1'b0;
      case (r_state)
         RUN: begin
            if (exc_req) begin
               w_latch_pc = 1'b1;
               if (stall_req_mem) begin
                  w_state_nxt = EXC_WAIT;
               end else begin
                  w_state_nxt   = FLUSH;
                  w_start_flush = 1'b1;
               end
            end
         end
         EXC_WAIT: begin
            // Redirect target was captured on entry; later exceptions are dropped.
            if (!stall_req_mem) begin
               w_state_nxt   = FLUSH;
               w_start_flush = 1'b1;
            end
         end
         FLUSH: begin
            if (r_flush_cnt <= 3'd1) w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   // EX counter only advances in RUN, saturates at the limit, clears on release.
   always_comb begin
      w_ex_cnt_nxt = r_ex_cnt;
      if (!stall_req_ex)
         w_ex_cnt_nxt = '0;
      else if (r_state == RUN && r_ex_cnt != EX_LIMIT)
         w_ex_cnt_nxt = r_ex_cnt + EX_CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= RUN;
         r_flush_cnt   <= '0;
         r_ex_cnt      <= '0;
         flush         <= 1'b0;
         flush_pc      <= '0;
         stall_cycles  <= '0;
         stall_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         flush   <= (w_state_nxt == FLUSH);

         if (w_latch_pc) flush_pc <= exc_pc;

         if (w_start_flush)
            r_flush_cnt <= FLUSH_LOAD;
         else if (r_state == FLUSH)
            r_flush_cnt <= r_flush_cnt - 3'd1;

         if (stall != STALL_NONE)
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);

         r_ex_cnt <= w_ex_cnt_nxt;
         if (w_ex_cnt_nxt == EX_LIMIT)
            stall_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

   localparam int FC  = 3;
   localparam int STO = 4;
   localparam int CW  = 32;
   localparam logic [31:0] PA = 32'hBFC00380;
   localparam logic [31:0] PB = 32'h80000180;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          lr1 = 1'b0, lr2 = 1'b0, rex = 1'b0, rmem = 1'b0, exc = 1'b0;
   logic [31:0]   epc = '0;
   logic [5:0]    stall;
   logic          flush;
   logic [31:0]   flush_pc;
   logic [CW-1:0] stall_cycles;
   logic          stall_timeout;

   typedef struct packed {
      logic [5:0]  st;
      logic        fl;
      logic [31:0] fpc;
      logic [31:0] cnt;
      logic        to;
      logic [7:0]  idx;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   vec_idx  = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(
      .FLUSH_CYCLES (FC),
      .STALL_TIMEOUT(STO),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_related_1(lr1),
      .load_related_2(lr2),
      .stall_req_ex  (rex),
      .stall_req_mem (rmem),
      .exc_req       (exc),
      .exc_pc        (epc),
      .stall         (stall),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .stall_cycles  (stall_cycles),
      .stall_timeout (stall_timeout)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // One vector per cycle: inputs applied just after the rising edge,
   // expected outputs for that same cycle queued for the monitor.
   task automatic step(input logic r, input logic l1, input logic l2, input logic ex,
                       input logic mem, input logic e, input logic [31:0] pc,
                       input logic [5:0] x_st, input logic x_fl, input logic [31:0] x_fpc,
                       input logic [31:0] x_cnt, input logic x_to);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; lr1 = l1; lr2 = l2; rex = ex; rmem = mem; exc = e; epc = pc;
      x.st = x_st; x.fl = x_fl; x.fpc = x_fpc; x.cnt = x_cnt; x.to = x_to;
      x.idx = 8'(vec_idx);
      sb_q.push_back(x);
      vec_idx++;
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("stall",         int'(x.idx), {26'd0, stall},         {26'd0, x.st});
            check("flush",         int'(x.idx), {31'd0, flush},         {31'd0, x.fl});
            check("flush_pc",      int'(x.idx), flush_pc,               x.fpc);
            check("stall_cycles",  int'(x.idx), stall_cycles,           x.cnt);
            check("stall_timeout", int'(x.idx), {31'd0, stall_timeout}, {31'd0, x.to});
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      //     rst l1 l2 ex mem exc pc     stall      fl fpc  cnt to
      // reset with every request high
      step(0, 1, 1, 1, 1, 1, PA,  6'b000000, 0, 0,  0,  0);
      // out of reset: MEM has priority
      step(1, 0, 0, 0, 1, 0, 0,   6'b011111, 0, 0,  0,  0);
      // single-cycle load hazard
      step(1, 1, 0, 0, 0, 0, 0,   6'b000111, 0, 0,  1,  0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 0, 0,  2,  0);
      // EX busy over load hazard, then hazard alone
      step(1, 0, 1, 1, 0, 0, 0,   6'b001111, 0, 0,  2,  0);
      step(1, 0, 1, 1, 0, 0, 0,   6'b001111, 0, 0,  3,  0);
      step(1, 0, 1, 1, 0, 0, 0,   6'b001111, 0, 0,  4,  0);
      step(1, 0, 1, 0, 0, 0, 0,   6'b000111, 0, 0,  5,  0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 0, 0,  6,  0);
      // exception without bus wait, flush 3 cycles, requests ignored
      step(1, 0, 0, 0, 0, 1, PA,  6'b111111, 0, 0,  6,  0);
      step(1, 0, 0, 1, 1, 1, PB,  6'b000000, 1, PA, 7,  0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 1, PA, 7,  0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 1, PA, 7,  0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 0, PA, 7,  0);
      // exception behind 4-cycle bus wait, second exception dropped
      step(1, 0, 0, 0, 1, 1, PA,  6'b111111, 0, PA, 7,  0);
      step(1, 0, 0, 0, 1, 1, PB,  6'b111111, 0, PA, 8,  0);
      step(1, 0, 0, 0, 1, 0, 0,   6'b111111, 0, PA, 9,  0);
      step(1, 0, 0, 0, 1, 0, 0,   6'b111111, 0, PA, 10, 0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b111111, 0, PA, 11, 0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 1, PA, 12, 0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 1, PA, 12, 0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 1, PA, 12, 0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 0, PA, 12, 0);
      // EX timeout after 4 stall edges, sticky afterwards
      step(1, 0, 0, 1, 0, 0, 0,   6'b001111, 0, PA, 12, 0);
      step(1, 0, 0, 1, 0, 0, 0,   6'b001111, 0, PA, 13, 0);
      step(1, 0, 0, 1, 0, 0, 0,   6'b001111, 0, PA, 14, 0);
      step(1, 0, 0, 1, 0, 0, 0,   6'b001111, 0, PA, 15, 0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 0, PA, 16, 1);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 0, PA, 16, 1);
      // new exception, then reset in the middle of the flush
      step(1, 0, 0, 0, 0, 1, PB,  6'b111111, 0, PA, 16, 1);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 1, PB, 17, 1);
      step(0, 0, 0, 0, 0, 0, 0,   6'b000000, 0, 0,  0,  0);
      step(1, 1, 0, 0, 0, 0, 0,   6'b000111, 0, 0,  0,  0);
      step(1, 0, 0, 0, 0, 0, 0,   6'b000000, 0, 0,  1,  0);

      repeat (3) @(posedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
